fft_frame_tx: RTL and testbench

- Double-buffered frame transmitter that drives the FFT bin stream consumed by `raiseFreq`: `fft_data`, `fft_valid`, `freq`, `fft_fin`.
- Collects one frame of `NBIN` complex bins written in order, then replays them as one bin per cycle with the bin index on `freq`.
- Two banks allow one frame to be written while the previous frame is streamed.
- One instance per FFT channel (fft1 and fft2) sits between the FFT core and `raiseFreq`.

---
 rtl/raise_freq_pkg.sv | 28 ++
 rtl/fft_bank_ram.sv | 33 +++
 rtl/fft_frame_tx.sv | 129 ++++++++++++
 tb/tb_fft_frame_tx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/raise_freq_pkg.sv
// Shared definitions for the FFT bin stream feeding raiseFreq.
//   DATA_W   : bin word width, {re[31:16], im[15:0]}
//   NBIN     : bins per frame (power of two)
//   FREQ_W   : width of the bin index
//   LAST_BIN : terminal value of the write/read bin counters
//   bank_st_t: life cycle of one frame bank
//   tx_st_t  : read-side sequencer states
package raise_freq_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned NBIN   = 64;
   localparam int unsigned FREQ_W = $clog2(NBIN);

   localparam logic [FREQ_W-1:0] LAST_BIN = FREQ_W'(NBIN - 1);

   typedef enum logic [1:0] {
      FREE,
      FILLING,
      FULL,
      SENDING
   } bank_st_t;

   typedef enum logic {
      IDLE,
      SEND
   } tx_st_t;

endpackage

// File: rtl/fft_bank_ram.sv
// Two-bank frame store: 2 x NBIN words of DATA_W bits.
//   clk        : write clock
//   i_we       : write enable
//   i_wr_bank  : bank selected for the write
//   i_wr_addr  : bin index written
//   i_wr_data  : word written
//   i_rd_bank  : bank selected for the read
//   i_rd_addr  : bin index read
//   o_rd_data  : asynchronous read data (registered by the caller)
module fft_bank_ram
   import raise_freq_pkg::*;
(
   input  logic              clk,
   input  logic              i_we,
   input  logic              i_wr_bank,
   input  logic [FREQ_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_rd_bank,
   input  logic [FREQ_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [DATA_W-1:0] r_mem [2*NBIN];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[{i_wr_bank, i_wr_addr}] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[{i_rd_bank, i_rd_addr}];

endmodule

// File: rtl/fft_frame_tx.sv
// Double-buffered FFT frame transmitter. Collects NBIN bins per frame into one
// bank while the other bank is replayed as one bin per cycle.
//   clk       : sole clock, rising edge
//   rst       : asynchronous active-high reset
//   in_data   : bin word from the FFT core, bin order 0..NBIN-1
//   in_valid  : in_data offered this cycle
//   in_ready  : current write bank can accept a word
//   ovf       : offered word dropped because the write bank is busy
//   fft_data  : streamed bin word (registered)
//   fft_valid : fft_data/freq valid this cycle
//   freq      : bin index of fft_data
//   fft_fin   : high while no frame is being streamed
module fft_frame_tx
   import raise_freq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              ovf,
   output logic [DATA_W-1:0] fft_data,
   output logic              fft_valid,
   output logic [FREQ_W-1:0] freq,
   output logic              fft_fin
);

   bank_st_t          r_bank_st [2];
   logic              r_wbank;
   logic              r_rbank;
   logic [FREQ_W-1:0] r_wcnt;
   logic [FREQ_W-1:0] r_rcnt;
   tx_st_t            r_state;
   logic [DATA_W-1:0] r_fft_data;
   logic              r_fft_valid;
   logic [FREQ_W-1:0] r_freq;
   logic              r_fft_fin;

   logic              w_in_ready;
   logic              w_accept;
   logic              w_other;
   logic [DATA_W-1:0] w_rd_data;

   assign w_in_ready = (r_bank_st[r_wbank] == FREE) || (r_bank_st[r_wbank] == FILLING);
   assign w_accept   = in_valid && w_in_ready;
   assign w_other    = ~r_rbank;

   fft_bank_ram u_ram (
      .clk       (clk),
      .i_we      (w_accept),
      .i_wr_bank (r_wbank),
      .i_wr_addr (r_wcnt),
      .i_wr_data (in_data),
      .i_rd_bank (r_rbank),
      .i_rd_addr (r_rcnt),
      .o_rd_data (w_rd_data)
   );

   // The write side only touches a FREE/FILLING bank and the read side only a
   // FULL/SENDING one, so both may update bank states in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bank_st[0] <= FREE;
         r_bank_st[1] <= FREE;
         r_wbank      <= 1'b0;
         r_rbank      <= 1'b0;
         r_wcnt       <= '0;
         r_rcnt       <= '0;
         r_state      <= IDLE;
         r_fft_data   <= '0;
         r_fft_valid  <= 1'b0;
         r_freq       <= '0;
         r_fft_fin    <= 1'b1;
      end else begin
         if (w_accept) begin
            if (r_wcnt == LAST_BIN) begin
               r_bank_st[r_wbank] <= FULL;
               r_wbank            <= ~r_wbank;
               r_wcnt             <= '0;
            end else begin
               r_bank_st[r_wbank] <= FILLING;
               r_wcnt             <= r_wcnt + FREQ_W'(1);
            end
         end

         case (r_state)
            IDLE: begin
               r_fft_data  <= '0;
               r_fft_valid <= 1'b0;
               r_freq      <= '0;
               r_fft_fin   <= 1'b1;
               if (r_bank_st[r_rbank] == FULL) begin
                  r_bank_st[r_rbank] <= SENDING;
                  r_rcnt             <= '0;
                  r_state            <= SEND;
               end
            end
            SEND: begin
               r_fft_data  <= w_rd_data;
               r_freq      <= r_rcnt;
               r_fft_valid <= 1'b1;
               r_fft_fin   <= 1'b0;
               if (r_rcnt == LAST_BIN) begin
                  r_bank_st[r_rbank] <= FREE;
                  r_rbank            <= w_other;
                  r_rcnt             <= '0;
                  // Chain straight into the other bank only if it was already full.
                  if (r_bank_st[w_other] == FULL) begin
                     r_bank_st[w_other] <= SENDING;
                  end else begin
                     r_state <= IDLE;
                  end
               end else begin
                  r_rcnt <= r_rcnt + FREQ_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = w_in_ready;
   assign ovf       = in_valid && !w_in_ready;
   assign fft_data  = r_fft_data;
   assign fft_valid = r_fft_valid;
   assign freq      = r_freq;
   assign fft_fin   = r_fft_fin;

endmodule

// File: tb/tb_fft_frame_tx.sv
// Bench for fft_frame_tx. A frame-level model predicts, for every accepted
// frame, the edge at which each bin must appear and when the write bank is
// free again; a monitor compares the DUT against those predictions.
module tb_fft_frame_tx;
   import raise_freq_pkg::*;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [DATA_W-1:0] in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              ovf;
   logic [DATA_W-1:0] fft_data;
   logic              fft_valid;
   logic [FREQ_W-1:0] freq;
   logic              fft_fin;

   fft_frame_tx dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ovf       (ovf),
      .fft_data  (fft_data),
      .fft_valid (fft_valid),
      .freq      (freq),
      .fft_fin   (fft_fin)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          edge_n;
      int          fr;
      logic [31:0] d;
   } bin_t;

   bin_t        exp_q[$];
   int          ends[$];
   logic [31:0] fill [64];
   int          wfill = 0;
   int          last_end = -1000;
   int          last_start = 0;
   int          checks = 0;
   int          errors = 0;
   bit          done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at cycle %0d: actual %0h required %0h", name, cyc, act, req);
      end
   endtask

   // Monitor / scoreboard
   initial begin
      bin_t b;
      bit   exp_rdy;
      int   k;
      int   s;
      forever begin
         @(negedge clk or posedge rst);
         if (rst) begin
            #1;
            chk("rst_valid", 32'(fft_valid), 0);
            chk("rst_fin", 32'(fft_fin), 1);
            chk("rst_data", fft_data, 0);
            chk("rst_freq", 32'(freq), 0);
            chk("rst_ready", 32'(in_ready), 1);
            chk("rst_ovf", 32'(ovf), 0);
            exp_q.delete();
            ends.delete();
            wfill    = 0;
            last_end = -1000;
         end else begin
            if (fft_valid) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_bin at cycle %0d: actual freq %0d required no output",
                           cyc, freq);
               end else begin
                  b = exp_q.pop_front();
                  chk("bin_cycle", cyc, b.edge_n);
                  chk("bin_freq", 32'(freq), b.fr);
                  chk("bin_data", fft_data, b.d);
               end
               chk("fin_streaming", 32'(fft_fin), 0);
            end else begin
               chk("fin_idle", 32'(fft_fin), 1);
               chk("idle_data", fft_data, 0);
               chk("idle_freq", 32'(freq), 0);
               chk("missed_bin", 32'(exp_q.size() > 0 && exp_q[0].edge_n <= cyc), 0);
               if (exp_q.size() > 0 && exp_q[0].edge_n <= cyc) void'(exp_q.pop_front());
            end

            // The bank for frame w was last used by frame w-2.
            exp_rdy = (ends.size() < 2) ? 1'b1 : (ends[ends.size() - 2] <= cyc);
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("ovf", 32'(ovf), 32'(in_valid && !exp_rdy));

            if (in_valid && exp_rdy) begin
               fill[wfill] = in_data;
               wfill++;
               if (wfill == 64) begin
                  k = cyc + 1;
                  s = (k + 2 > last_end + 1) ? k + 2 : last_end + 1;
                  for (int n = 0; n < 64; n++) begin
                     exp_q.push_back('{edge_n: s + n, fr: n, d: fill[n]});
                  end
                  last_start = s;
                  last_end   = s + 63;
                  ends.push_back(last_end);
                  wfill = 0;
               end
            end
         end
         if (done) begin
            chk("queue_drained", 32'(exp_q.size()), 0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
      end
   end

   task automatic drive(input logic v, input logic [31:0] d);
      in_valid = v;
      in_data  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_data  = '0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_reset();
      in_valid = 1'b0;
      #1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Stimulus
   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      // Single frame with a recognisable pattern.
      for (int i = 0; i < 64; i++) drive(1'b1, 32'h0001_0000 * i + i);
      idle(80);

      // Two frames back to back.
      for (int i = 0; i < 128; i++) drive(1'b1, $urandom);
      idle(150);

      // Three-plus frames offered continuously; the write bank runs into a busy bank.
      for (int i = 0; i < 224; i++) drive(1'b1, $urandom);
      idle(200);

      // Clean start, then reset while bin 20 is on the output.
      pulse_reset();
      idle(2);
      for (int i = 0; i < 64; i++) drive(1'b1, $urandom);
      in_valid = 1'b0;
      while (cyc < last_start + 20) begin
         @(posedge clk);
         #1;
      end
      pulse_reset();
      idle(2);
      for (int i = 0; i < 64; i++) drive(1'b1, 32'hA5A5_0000 + i);
      idle(100);

      // Gapped writes.
      for (int i = 0; i < 128; i++) drive((i % 2) == 0, $urandom);
      idle(100);

      // Random traffic.
      for (int i = 0; i < 600; i++) drive($urandom_range(0, 9) != 0, $urandom);
      idle(300);

      done = 1'b1;
      idle(5);
      $display("FAIL monitor_timeout at cycle %0d: actual no summary required summary", cyc);
      $fatal(1, "monitor did not finish");
   end

endmodule
